// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared FSM encoding and counter-width helpers for fetch_sequencer.
// Rev     : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_COMMIT = 2'd1,
        F_DONE   = 2'd2
    } fetch_state_t;

    localparam int STATE_W = 2;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int PRESC_W_DEF = $clog2(25_000_000);
    localparam int DEB_W_DEF   = $clog2(250_000);

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_detect
// Brief   : 2-flop synchroniser, optional debounce (FETCH_DEBOUNCE_EN), rising-edge pulse.
// Rev     : 1.0
// ============================================================================
module sync_edge_detect
    import fetch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic filt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef FETCH_DEBOUNCE_EN
    localparam int DW = cnt_width(DEBOUNCE_CYC);

    logic [DW-1:0] deb_cnt_q;
    logic          deb_q;

    // Any sample equal to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
        end else if (sync2_q == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
            deb_cnt_q <= '0;
            deb_q     <= sync2_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
        end
    end

    assign filt = deb_q;
`else
    assign filt = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise_o = filt & ~prev_q & (DEBOUNCE_CYC >= 1);

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Brief   : PC sequencer with one-cycle commit per step/tick; FETCH_DEBOUNCE_EN adds step debounce.
// Rev     : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = 3,
    parameter int PROG_LEN     = 8,
    parameter int WRAP         = 1,
    parameter int RUN_DIV      = 25_000_000,
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic              run_sw,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              commit,
    output logic              reg_write_out,
    output logic              mem_write_out,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int              PW   = cnt_width(RUN_DIV);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    logic              step_pulse;
    logic              run_s1_q;
    logic              run_s2_q;
    logic [PW-1:0]     presc_q;
    logic              tick;
    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    sync_edge_detect #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_step_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (step_btn),
        .rise_o (step_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            run_s1_q <= run_sw;
            run_s2_q <= run_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (!run_s2_q || (presc_q == PW'(RUN_DIV - 1))) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick = run_s2_q & (presc_q == PW'(RUN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= F_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            F_IDLE: begin
                if ((run_s2_q && tick) || (!run_s2_q && step_pulse)) begin
                    state_d = F_COMMIT;
                end
            end
            F_COMMIT: begin
                if (addr_q != LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = F_IDLE;
                end else if (WRAP != 0) begin
                    addr_d  = '0;
                    state_d = F_IDLE;
                end else begin
                    state_d = F_DONE;
                end
            end
            F_DONE:  state_d = F_DONE;
            default: state_d = F_IDLE;
        endcase
    end

    // Commit is a pure state decode, so the write gates cannot glitch.
    assign commit        = (state_q == F_COMMIT);
    assign reg_write_out = reg_write_in & commit;
    assign mem_write_out = mem_write_in & commit;
    assign instr_addr    = addr_q;
    assign state_dbg     = state_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Directed self-checking bench; dut_a wraps (PROG_LEN 8), dut_b stops (PROG_LEN 5).
// Rev     : 1.0
// ============================================================================
module tb_fetch_sequencer;

`ifdef FETCH_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       rst;
    logic       step_btn;
    logic       run_sw;
    logic       rw_in;
    logic       mw_in;
    logic [2:0] addr_a, addr_b;
    logic       commit_a, commit_b;
    logic       rwo_a, rwo_b, mwo_a, mwo_b;
    logic [1:0] state_a, state_b;

    int checks = 0;
    int errors = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;
    int cnt_rw = 0;
    int cnt_mw = 0;

    fetch_sequencer #(
        .ADDR_W(3), .PROG_LEN(8), .WRAP(1), .RUN_DIV(4), .DEBOUNCE_CYC(4)
    ) dut_a (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw),
        .reg_write_in(rw_in), .mem_write_in(mw_in), .instr_addr(addr_a),
        .commit(commit_a), .reg_write_out(rwo_a), .mem_write_out(mwo_a),
        .state_dbg(state_a)
    );

    fetch_sequencer #(
        .ADDR_W(3), .PROG_LEN(5), .WRAP(0), .RUN_DIV(4), .DEBOUNCE_CYC(4)
    ) dut_b (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw),
        .reg_write_in(rw_in), .mem_write_in(mw_in), .instr_addr(addr_b),
        .commit(commit_b), .reg_write_out(rwo_b), .mem_write_out(mwo_b),
        .state_dbg(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (commit_a === 1'b1) cnt_a++;
        if (commit_b === 1'b1) cnt_b++;
        if (rwo_a === 1'b1)    cnt_rw++;
        if (mwo_a === 1'b1)    cnt_mw++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_phase(input int ncyc, input bit with_steps);
        logic exp_c;
        run_sw = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            exp_c = (i >= 5) && (((i - 5) % 4) == 0);
            chk("run_commit", 32'(commit_a), 32'(exp_c));
            if (with_steps && i == 8)  step_btn = 1'b1;
            if (with_steps && i == 14) step_btn = 1'b0;
        end
        run_sw = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    int   base_a, base_b, base_rw, base_mw;
    bit   found;
    logic exp_c;
    int   exp_wrap [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        rst = 1'b0; step_btn = 1'b0; run_sw = 1'b0; rw_in = 1'b1; mw_in = 1'b0;

        #1;
        chk("reset_addr",   32'(addr_a),   0);
        chk("reset_commit", 32'(commit_a), 0);
        chk("reset_state",  32'(state_a),  0);
        chk("reset_rwo",    32'(rwo_a),    0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_addr",  32'(addr_a),  0);
        chk("idle_state", 32'(state_a), 0);

        // Single step held 20 cycles: one commit LAT edges after first sample.
        base_a = cnt_a; base_rw = cnt_rw; base_mw = cnt_mw;
        step_btn = 1'b1;
        for (int i = 0; i <= LAT + 1; i++) begin
            @(negedge clk);
            exp_c = (i == LAT);
            chk("step_commit", 32'(commit_a), 32'(exp_c));
            chk("step_rwo",    32'(rwo_a),    32'(exp_c));
            chk("step_mwo",    32'(mwo_a),    0);
            chk("step_addr",   32'(addr_a),   (i <= LAT) ? 0 : 1);
            if (i == LAT) chk("step_state", 32'(state_a), 1);
        end
        repeat (20 - (LAT + 2)) @(negedge clk);
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("step_count", 32'(cnt_a - base_a),   1);
        chk("step_rwcnt", 32'(cnt_rw - base_rw), 1);
        chk("step_mwcnt", 32'(cnt_mw - base_mw), 0);
        chk("step_addr1", 32'(addr_a), 1);

        press();
        press();
        chk("pre_mid_addr", 32'(addr_a), 3);

        // Reset dropped while committing at address 3.
        step_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (commit_a === 1'b1) found = 1'b1;
        end
        chk("mid_found", 32'(found), 1);
        chk("mid_addr_before", 32'(addr_a), 3);
        step_btn = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_addr",   32'(addr_a),   0);
        chk("mid_commit", 32'(commit_a), 0);
        chk("mid_state",  32'(state_a),  0);
        chk("mid_rwo",    32'(rwo_a),    0);
        base_a = cnt_a;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_commit", 32'(cnt_a - base_a), 0);
        chk("mid_addr_hold", 32'(addr_a), 0);

        // Wrap on dut_a, stop-at-end on dut_b.
        do_reset();
        rw_in = 1'b0; mw_in = 1'b1;
        base_a = cnt_a; base_b = cnt_b; base_rw = cnt_rw; base_mw = cnt_mw;
        for (int i = 0; i < 9; i++) begin
            press();
            chk("wrap_addr", 32'(addr_a), 32'(exp_wrap[i]));
            if (i == 6) begin
                chk("done_count", 32'(cnt_b - base_b), 5);
                chk("done_addr",  32'(addr_b),  4);
                chk("done_state", 32'(state_b), 2);
            end
        end
        chk("wrap_count", 32'(cnt_a - base_a),   9);
        chk("wrap_mwcnt", 32'(cnt_mw - base_mw), 9);
        chk("wrap_rwcnt", 32'(cnt_rw - base_rw), 0);
        chk("done_count_final", 32'(cnt_b - base_b), 5);
        chk("done_commit_low",  32'(commit_b), 0);

        // Auto-run: RUN_DIV=4, steps ignored, prescaler cleared when run drops.
        do_reset();
        base_a = cnt_a;
        run_phase(20, 1'b1);
        chk("run_count_a", 32'(cnt_a - base_a), 5);
        run_phase(7, 1'b0);
        chk("run_count_b", 32'(cnt_a - base_a), 6);
        run_phase(20, 1'b0);
        chk("run_count_c", 32'(cnt_a - base_a), 11);
        chk("run_addr",    32'(addr_a),  3);
        chk("run_b_addr",  32'(addr_b),  4);
        chk("run_b_state", 32'(state_b), 2);

`ifdef FETCH_DEBOUNCE_EN
        do_reset();
        base_a = cnt_a;
        for (int i = 0; i < 8; i++) begin
            step_btn = ((i % 2) == 0);
            @(negedge clk);
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_none", 32'(cnt_a - base_a), 0);
        step_btn = 1'b1;
        repeat (10) @(negedge clk);
        step_btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("bounce_one", 32'(cnt_a - base_a), 1);
`else
        do_reset();
        base_a = cnt_a;
        step_btn = 1'b1;
        @(negedge clk);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("short_press", 32'(cnt_a - base_a), 1);
        chk("short_addr",  32'(addr_a), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
